// File: rtl/demux1_2_wide_reg.sv
// ---------------------------------------------------------------------------
// demux1_2_wide_reg
//
// Purpose:
//   1-to-2 demultiplexer with one single-entry register buffer per
//   destination. A word offered on the input (valid/ready handshake) is
//   steered by sel into buffer[sel]. Each buffer presents its word on
//   out_data[k] with out_valid[k] until destination k takes it with
//   out_ready[k]. The two buffers are fully independent. A full buffer
//   stalls only words aimed at it.
//
// Ports:
//   clk         in   1            single clock, rising edge
//   reset       in   1            asynchronous reset, active low
//   in_data     in   WIDTH        word offered by the upstream producer
//   in_valid    in   1            in_data holds a word
//   sel         in   1            destination index for the offered word
//   in_ready    out  1            offered word is accepted this cycle
//   out_data    out  WIDTH x[0:1] buffered word per destination
//   out_valid   out  2            out_data[k] holds an undelivered word
//   out_ready   in   2            destination k consumes out_data[k]
//   xfer_count  out  16 x[0:1]    output transfer count per destination
//                                 (only with DEMUX_XFER_COUNT_EN)
//
// Configuration:
//   DEMUX_XFER_COUNT_EN  when defined, adds the xfer_count output and one
//                        wrapping 16-bit output-transfer counter per
//                        destination. Undefined by default.
// ---------------------------------------------------------------------------
module demux1_2_wide_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data [0:1],
    output logic [1:0]       out_valid,
    input  logic [1:0]       out_ready
`ifdef DEMUX_XFER_COUNT_EN
    ,
    output logic [15:0]      xfer_count [0:1]
`endif
);

    logic [1:0] load;
    logic [1:0] drain;

    // The targeted buffer can take a word if it is empty, or if it is being
    // drained on this same edge (pass-through with no bubble). in_valid is
    // deliberately not part of this term.
    assign in_ready = ~out_valid[sel] | out_ready[sel];

    always_comb begin
        load     = 2'b00;
        load[0]  = in_valid & in_ready & ~sel;
        load[1]  = in_valid & in_ready & sel;
    end

    assign drain = out_valid & out_ready;

    // A load takes priority over a drain: when both hit the same buffer the
    // new word replaces the delivered one and out_valid stays high.
    // out_data is only written on a load, so it holds after a drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 2'b00;
            out_data[0] <= '0;
            out_data[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (load[k]) begin
                    out_data[k]  <= in_data;
                    out_valid[k] <= 1'b1;
                end else if (drain[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_XFER_COUNT_EN
    // Free-running counters; natural 16-bit overflow gives the FFFF->0000 wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_count[0] <= '0;
            xfer_count[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (drain[k]) begin
                    xfer_count[k] <= xfer_count[k] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux1_2_wide_reg.sv
module tb_demux1_2_wide_reg;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             sel;
    logic             in_ready;
    logic [WIDTH-1:0] out_data [0:1];
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
`ifdef DEMUX_XFER_COUNT_EN
    logic [15:0]      xfer_count [0:1];
`endif

    demux1_2_wide_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sel       (sel),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_XFER_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each destination is a FIFO of capacity one.
    logic [WIDTH-1:0] exp_q [2][$];
    logic             occupied [2];
    logic [WIDTH-1:0] last_word [2];
    logic [15:0]      cnt_model [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            occupied[k]  = 1'b0;
            last_word[k] = '0;
            cnt_model[k] = 16'd0;
        end
    endtask

    // One clock cycle: drive after the rising edge, check and advance the
    // model at the falling edge (state there is the result of the last edge,
    // inputs are those that the coming edge will act on).
    task automatic step(input logic iv, input logic s, input logic [WIDTH-1:0] d,
                        input logic [1:0] ordy);
        logic exp_rdy;
        logic acc;
        @(posedge clk);
        #1;
        in_valid  = iv;
        sel       = s;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = !occupied[s] || ordy[s];
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        for (int k = 0; k < 2; k++) begin
            check(k == 0 ? "out_valid0" : "out_valid1", {63'd0, out_valid[k]}, {63'd0, occupied[k]});
            check(k == 0 ? "out_data0_hold" : "out_data1_hold", out_data[k], last_word[k]);
`ifdef DEMUX_XFER_COUNT_EN
            check(k == 0 ? "xfer_count0" : "xfer_count1", {48'd0, xfer_count[k]}, {48'd0, cnt_model[k]});
`endif
        end
        acc = iv && exp_rdy;
        for (int k = 0; k < 2; k++) begin
            if (occupied[k] && ordy[k]) begin
                occupied[k]  = 1'b0;
                cnt_model[k] = cnt_model[k] + 16'd1;
            end
        end
        if (acc) begin
            exp_q[s].push_back(d);
            occupied[s]  = 1'b1;
            last_word[s] = d;
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs are checked before any
    // clock edge occurs, then released just after a falling edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("rst_out_valid", {62'd0, out_valid}, 64'd0);
        check("rst_out_data0", out_data[0], 64'd0);
        check("rst_out_data1", out_data[1], 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        model_clear();
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: every output transfer must deliver the oldest expected word.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check(k == 0 ? "spurious_word0" : "spurious_word1", out_data[k], 64'd0);
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_delivery%0d: got %h expected no word", k, out_data[k]);
                    end else begin
                        check(k == 0 ? "deliver0" : "deliver1", out_data[k], exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        sel       = 1'b0;
        in_data   = '0;
        out_ready = 2'b00;
        model_clear();
        #1;
        check("por_out_valid", {62'd0, out_valid}, 64'd0);
        check("por_out_data0", out_data[0], 64'd0);
        check("por_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Basic route to destination 1; buffer 0 untouched.
        step(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 2'b00);
        step(1'b0, 1'b0, '0, 2'b00);
        check("route_out_valid", {62'd0, out_valid}, 64'd2);
        check("route_out_data1", out_data[1], 64'hDEAD_BEEF_0000_0001);
        check("route_out_data0", out_data[0], 64'd0);

        // Backpressure on buffer 0 while buffer 1 still drains.
        step(1'b1, 1'b0, rand_word(), 2'b00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rand_word(), 2'b10);
        step(1'b1, 1'b1, rand_word(), 2'b00);
        step(1'b0, 1'b0, '0, 2'b11);
        step(1'b0, 1'b0, '0, 2'b11);

        // Full throughput on destination 0.
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, rand_word(), 2'b01);
        step(1'b0, 1'b0, '0, 2'b01);
        step(1'b0, 1'b0, '0, 2'b00);
        #1;
        check("throughput_drained", 64'(exp_q[0].size()), 64'd0);

        // Reset mid-stream with both buffers full.
        step(1'b1, 1'b0, rand_word(), 2'b00);
        step(1'b1, 1'b1, rand_word(), 2'b00);
        step(1'b0, 1'b0, '0, 2'b00);
        do_reset();
        step(1'b0, 1'b0, '0, 2'b11);
        step(1'b0, 1'b1, '0, 2'b11);

        // Randomized traffic, with an occasional reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_word(),
                 2'($urandom_range(0, 3)));
        end

`ifdef DEMUX_XFER_COUNT_EN
        // Counter wrap on destination 0; destination 1 must not move.
        do_reset();
        step(1'b1, 1'b1, rand_word(), 2'b00);
        while (cnt_model[0] != 16'hFFFF) step(1'b1, 1'b0, rand_word(), 2'b01);
        step(1'b1, 1'b0, rand_word(), 2'b01);
        check("count_at_ffff", {48'd0, xfer_count[0]}, 64'h0000_0000_0000_FFFF);
        step(1'b0, 1'b0, '0, 2'b00);
        check("count_wrapped", {48'd0, xfer_count[0]}, 64'd0);
        check("count1_unchanged", {48'd0, xfer_count[1]}, 64'd0);
`endif

        step(1'b0, 1'b0, '0, 2'b00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1_2_wide_reg.md
DEMUX1_2_WIDE_REG -- requirements
Module: demux1_2_wide_reg

Interface
REQ-001 Parameter WIDTH, default 64: data width of every input and output word.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 in_data  input  WIDTH  word offered by the upstream producer.
REQ-005 in_valid  input  1  upstream word present on in_data.
REQ-006 sel  input  1  destination index (0 or 1) for the offered word; sampled with in_data.
REQ-007 in_ready  output  1  block accepts the offered word this cycle.
REQ-008 out_data  output  WIDTH x [0:1]  unpacked array; out_data[k] is the buffered word for destination k.
REQ-009 out_valid  output  2  out_valid[k] set when out_data[k] holds an undelivered word.
REQ-010 out_ready  input  2  out_ready[k] set when destination k consumes out_data[k] this cycle.

Function
REQ-011 One single-entry register buffer per destination k (data + valid flag); the two buffers are fully independent.
REQ-012 Input transfer occurs on a rising edge where in_valid and in_ready are both 1; the word loads into buffer[sel].
REQ-013 Output transfer on destination k occurs on a rising edge where out_valid[k] and out_ready[k] are both 1.
REQ-014 in_ready SHALL equal (~out_valid[sel]) | out_ready[sel], purely combinational from current state and inputs; independent of in_valid.
REQ-015 Latency: a word accepted at edge N appears on out_data[sel] with out_valid[sel]=1 immediately after edge N (one-cycle latency).
REQ-016 Simultaneous output transfer and input transfer into the same buffer: buffer loads the new word and out_valid stays 1; no bubble, no loss.
REQ-017 Output transfer on k with no input transfer into k: out_valid[k] clears at that edge; out_data[k] holds its last value.
REQ-018 Buffer k full with out_ready[k]=0 and sel=k: in_ready=0; buffer k unchanged; the other buffer is unaffected and may still drain.
REQ-019 Words routed to the same destination are delivered in acceptance order; no ordering relationship between destinations.
REQ-020 Changes to sel or in_data while in_ready=0 have no effect on state.
REQ-021 out_data[k] SHALL change only on an input transfer into buffer k.

Reset
REQ-022 While reset=0: out_valid=2'b00 and out_data[0], out_data[1]=0, immediately (asynchronously), independent of clk.
REQ-023 Reset asserted mid-operation discards both buffered words; no partial or stale word is delivered after release.
REQ-024 First input transfer possible on the first rising edge with reset=1; in_ready=1 throughout reset.

Configuration
REQ-025 Macro DEMUX_XFER_COUNT_EN: when defined, adds output xfer_count  output  16 x [0:1]; xfer_count[k] increments by 1 on each output transfer on destination k.
REQ-026 With DEMUX_XFER_COUNT_EN: counters reset to 0 asynchronously; wrap 16'hFFFF -> 16'h0000; simultaneous transfers on both destinations increment both counters in the same cycle.
REQ-027 Without DEMUX_XFER_COUNT_EN: xfer_count port and counter logic absent; all other behaviour identical.

Verification
REQ-028 Reset: reset=0 with buffers full -> out_valid=00, out_data both 0 before next clk edge; in_ready=1.
REQ-029 Basic route: in_data=64'hDEAD_BEEF_0000_0001, sel=1, in_valid=1, out_ready=00 -> after one edge out_valid=10, out_data[1]=64'hDEAD_BEEF_0000_0001, out_data[0] unchanged.
REQ-030 Backpressure: buffer 0 full, out_ready[0]=0, sel=0 -> in_ready=0 for 5 cycles, out_data[0] stable; switch sel=1 -> in_ready=1, word lands in buffer 1.
REQ-031 Full throughput: sel=0, in_valid=1, out_ready[0]=1 for 32 consecutive random words -> in_ready=1 every cycle, 32 words delivered in order, no bubbles.
REQ-032 Reset mid-stream: reset=0 for one cycle with out_valid=11 -> after release out_valid=00, no old word ever observed with out_valid=1.
REQ-033 With DEMUX_XFER_COUNT_EN: preload 65535 transfers on destination 0 -> xfer_count[0]=16'hFFFF; one more transfer -> 16'h0000; xfer_count[1] unchanged.
